// File: rtl/seq_pkg.sv
// Shared encodings for the 10101 serializer/detector pair: FSM state codes
// and the target bit pattern used by the detector and by benches.
package seq_pkg;

  typedef logic [1:0] seq_state_t;

  localparam seq_state_t ST_IDLE   = 2'd0;
  localparam seq_state_t ST_SHIFT  = 2'd1;
  localparam seq_state_t ST_GAP    = 2'd2;
  localparam seq_state_t ST_PARITY = 2'd3;

  localparam int         SEQ_PATTERN_W = 5;
  localparam logic [4:0] SEQ_PATTERN   = 5'b10101;

endpackage

// File: rtl/seq_serializer_if.sv
// Word-in / bit-out bus of the serializer; the serializer sits on the slave
// modport, the word source and stream monitors on the master modport.
interface seq_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             xout;
  logic             xout_valid;
  logic             busy;
  logic             frame_done;

  modport master (
    output din, din_valid,
    input  din_ready, xout, xout_valid, busy, frame_done
  );

  modport slave (
    input  din, din_valid,
    output din_ready, xout, xout_valid, busy, frame_done
  );
endinterface

// File: rtl/seq_serializer.sv
// MSB-first parallel-to-serial stage feeding the 10101 detector, with GAP idle
// cycles between frames. Define SEQ_SERIALIZER_PARITY_EN to append an even-parity bit.
module seq_serializer
  import seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GAP   = 0
) (
  input logic              clk,
  input logic              rst,
  seq_serializer_if.slave  bus
);

  localparam int BCW = $clog2(WIDTH);
  localparam int GCW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

  seq_state_t       state;
  logic [WIDTH-1:0] sreg;
  logic [BCW-1:0]   bcnt;
  logic [GCW-1:0]   gcnt;
`ifdef SEQ_SERIALIZER_PARITY_EN
  logic             par;
`endif

  logic last_bit;
  logic frame_end;
  logic din_ready_c;
  logic xout_c;
  logic xout_valid_c;
  logic accept;

  always_comb begin
    last_bit = (state == ST_SHIFT) && (bcnt == LAST_BIT);
`ifdef SEQ_SERIALIZER_PARITY_EN
    frame_end    = (state == ST_PARITY);
    xout_valid_c = (state == ST_SHIFT) || (state == ST_PARITY);
    xout_c       = (state == ST_SHIFT)  ? sreg[WIDTH-1] :
                   (state == ST_PARITY) ? par : 1'b0;
`else
    frame_end    = last_bit;
    xout_valid_c = (state == ST_SHIFT);
    xout_c       = (state == ST_SHIFT) ? sreg[WIDTH-1] : 1'b0;
`endif
    // With no gap, the final cycle of a frame already takes the next word.
    din_ready_c = (state == ST_IDLE) || ((GAP == 0) && frame_end);
    accept      = bus.din_valid && din_ready_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      sreg  <= '0;
      bcnt  <= '0;
      gcnt  <= '0;
`ifdef SEQ_SERIALIZER_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_SHIFT: begin
          sreg <= {sreg[WIDTH-2:0], 1'b0};
          bcnt <= bcnt + BCW'(1);
`ifdef SEQ_SERIALIZER_PARITY_EN
          if (last_bit) state <= ST_PARITY;
`endif
        end
        ST_GAP: begin
          gcnt <= gcnt - GCW'(1);
          if (gcnt == GCW'(1)) state <= ST_IDLE;
        end
        default: ;
      endcase

      if (frame_end) begin
        if (GAP > 0) begin
          state <= ST_GAP;
          gcnt  <= GCW'(GAP);
        end else begin
          state <= ST_IDLE;
        end
      end

      // A load overrides any frame-end transition above.
      if (accept) begin
        state <= ST_SHIFT;
        sreg  <= bus.din;
        bcnt  <= '0;
`ifdef SEQ_SERIALIZER_PARITY_EN
        par   <= ^bus.din;
`endif
      end
    end
  end

  assign bus.din_ready  = din_ready_c;
  assign bus.xout       = xout_c;
  assign bus.xout_valid = xout_valid_c;
  assign bus.busy       = (state != ST_IDLE);
  assign bus.frame_done = frame_end;

endmodule
